// File: rtl/instr_exec_unit.sv
// instr_exec_unit: execute stage with 1-cycle ALU ops and iterative signed DIV/MOD; INSTR_EXEC_PERF_CNT_EN adds perf counters
module instr_exec_unit #(
  parameter int OP_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_opc,
  input  logic [OP_W-1:0]     in_op_a,
  input  logic [OP_W-1:0]     in_op_b,
  input  logic [ADDR_W-1:0]   in_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*OP_W-1:0]   out_result,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err
`ifdef INSTR_EXEC_PERF_CNT_EN
  ,
  output logic [31:0]         perf_instr_cnt,
  output logic [31:0]         perf_busy_cnt,
  output logic [15:0]         perf_err_cnt
`endif
);
  localparam int RW = 2*OP_W;
  localparam int CW = $clog2(OP_W);
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  state_t state, state_n;
  logic is_mod, neg_q, neg_r, accept, is_div, div_go, last;
  logic [OP_W-1:0] quo, rem, dvs, quo_n, rem_n, abs_a, abs_b;
  logic [OP_W:0] rem_sh, diff;
  logic [CW-1:0] cnt;
  logic [RW-1:0] sa, sb, alu, q_ext, r_ext;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign is_div = in_opc == 4'd6 || in_opc == 4'd7;
  assign div_go = is_div && in_op_b != '0;
  assign last = cnt == CW'(OP_W-1);
  assign sa = {{OP_W{in_op_a[OP_W-1]}}, in_op_a};
  assign sb = {{OP_W{in_op_b[OP_W-1]}}, in_op_b};
  assign abs_a = in_op_a[OP_W-1] ? -in_op_a : in_op_a;
  assign abs_b = in_op_b[OP_W-1] ? -in_op_b : in_op_b;
  // one restoring-division step: shift in next dividend bit, subtract if it fits
  assign rem_sh = {rem, quo[OP_W-1]};
  assign diff = rem_sh - {1'b0, dvs};
  assign quo_n = {quo[OP_W-2:0], ~diff[OP_W]};
  assign rem_n = diff[OP_W] ? rem_sh[OP_W-1:0] : diff[OP_W-1:0];
  assign q_ext = {{OP_W{1'b0}}, quo_n};
  assign r_ext = {{OP_W{1'b0}}, rem_n};
  // single-cycle ops on sign-extended operands; DIV/MOD and illegal opcodes give 0 here
  always_comb begin
    alu = '0;
    case (in_opc)
      4'd1: alu = sa;
      4'd2: alu = sb;
      4'd3: alu = sa + sb;
      4'd4: alu = sa - sb;
      4'd5: alu = sa * sb;
      default: alu = '0;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next-state logic
  always_comb begin
    state_n = state == IDLE ? (in_valid ? (div_go ? DIVIDE : DONE) : IDLE) :
              state == DIVIDE ? (last ? DONE : DIVIDE) :
              state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // capture instruction, step divider, and hold result until handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      out_result <= '0;
      out_addr <= '0;
      out_err <= 1'b0;
      is_mod <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (accept) begin
      out_result <= alu;
      out_addr <= in_addr;
      out_err <= in_opc[3] || (is_div && in_op_b == '0);
      is_mod <= in_opc[0];
      neg_q <= in_op_a[OP_W-1] ^ in_op_b[OP_W-1];
      neg_r <= in_op_a[OP_W-1];
      quo <= abs_a;
      rem <= '0;
      dvs <= abs_b;
      cnt <= '0;
    end else if (state == DIVIDE) begin
      quo <= quo_n;
      rem <= rem_n;
      cnt <= cnt + CW'(1);
      if (last) out_result <= is_mod ? (neg_r ? -r_ext : r_ext) : (neg_q ? -q_ext : q_ext);
    end
  end
`ifdef INSTR_EXEC_PERF_CNT_EN
  // handshake, busy-cycle and error counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_instr_cnt <= '0;
      perf_busy_cnt <= '0;
      perf_err_cnt <= '0;
    end else begin
      if (out_valid && out_ready) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (out_valid && out_ready && out_err) perf_err_cnt <= perf_err_cnt + 16'd1;
      if (state != IDLE) perf_busy_cnt <= perf_busy_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Execution stage directly downstream of the instruction register.
- Accepts one decoded instruction per handshake: opcode, two signed 32-bit operands, and a 5-bit register address.
- Computes the signed 64-bit result and returns it with the originating address, so the instruction register entry can be written back.
- Arithmetic ops complete in one cycle; DIV and MOD use an iterative shift-subtract divider.

Parameters:
- OP_W, 32: operand width; the result width is 2*OP_W.
- ADDR_W, 5: instruction register address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  the unit can accept an instruction.
- in_opc  in  4  opcode: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- in_op_a  in  OP_W  signed operand A.
- in_op_b  in  OP_W  signed operand B.
- in_addr  in  ADDR_W  register address of the instruction.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  2*OP_W  signed result.
- out_addr  out  ADDR_W  address captured with the instruction.
- out_err  out  1  divide-by-zero or illegal opcode.

Behaviour:
- Reset: synchronous, active-high. Next edge sets state=IDLE, in_ready=1, out_valid=0, out_result=0, out_addr=0, out_err=0, and clears the divider registers. Reset mid-divide abandons the operation; no output is produced.
- States: IDLE, DIVIDE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture opc, operands and addr.
  - Opcodes 0-5 or 8-15: compute the result and go to DONE.
  - DIV/MOD with op_b!=0: load the divider and go to DIVIDE.
  - DIV/MOD with op_b==0: out_result=0, out_err=1, go to DONE.
- DIVIDE:
  - in_ready=0.
  - Restoring division on |op_a| and |op_b|, one quotient bit per cycle, exactly OP_W cycles, then DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_result, out_addr and out_err are held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE and drop out_valid the next cycle.
- Latency (accept at edge T):
  - Non-divide ops: out_valid from T+1.
  - DIV/MOD: out_valid from T+1+OP_W, i.e. T+33 at default.
  - Throughput: at most one instruction per 2 cycles, since in_ready is high only in IDLE.
- Arithmetic (operands sign-extended to 2*OP_W before the op; no truncation):
  - ZERO -> 0.
  - PASSA -> op_a.
  - PASSB -> op_b.
  - ADD -> op_a+op_b.
  - SUB -> op_a-op_b.
  - MULT -> full signed 2*OP_W product.
  - DIV -> quotient truncated toward zero.
  - MOD -> remainder with the sign of op_a.
  - DIV/MOD results are sign-extended to 2*OP_W.
  - Quotient -2^31 / -1 = +2^31; this is representable in 64 bits and raises no error.
- Illegal opcodes 8-15: out_result=0, out_err=1.
- out_err is 0 for all legal cases other than divide-by-zero.
- in_valid while in_ready=0 is ignored. The upstream holds it; the unit does not queue.
- Outputs are registered; no combinational path from in_* to out_*.

Optional Feature:
- Macro: INSTR_EXEC_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_instr_cnt [31:0]: count of completed out handshakes.
  - perf_busy_cnt [31:0]: count of cycles spent in DIVIDE or DONE.
  - perf_err_cnt [15:0]: count of completed handshakes with out_err=1.
- All three counters reset to 0 and wrap on overflow.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD op_a=5, op_b=-12, addr=3, out_ready=1 -> out_valid one cycle after accept; out_result=-7 (64'hFFFF_FFFF_FFFF_FFF9), out_addr=3, out_err=0.
- MULT op_a=32'h7FFF_FFFF, op_b=32'h7FFF_FFFF -> out_result=64'h3FFF_FFFF_0000_0001.
- DIV op_a=-7, op_b=2, then MOD with the same operands:
  - DIV -> out_result=-3, out_valid exactly 33 cycles after accept.
  - MOD -> out_result=-1.
  - Also DIV 32'h8000_0000 / -1 -> 64'h0000_0000_8000_0000, out_err=0.
- DIV op_a=9, op_b=0; opcode 4'hC -> out_result=0, out_err=1, latency 1 cycle.
- ADD 1+1 with out_ready held 0 for 5 cycles:
  - out_valid and data stable throughout; in_ready=0 throughout.
  - A second in_valid during the stall is not accepted.
  - Released on out_ready=1.
- Assert reset on the 10th DIVIDE cycle -> next cycle state IDLE, out_valid=0, in_ready=1. A following PASSB op_b=42 returns 42. With INSTR_EXEC_PERF_CNT_EN, perf_instr_cnt=1.
